// File: rtl/acc_dump_if.sv
// acc_dump_if: output port of the integrate-and-dump controller.
//
// Handshake: the producer raises dump_valid while dump_data and dump_index
// hold an unconsumed dump. A transfer completes on a rising clk edge
// where dump_valid and dump_ready are both 1. While dump_valid=1 and
// dump_ready=0, the producer keeps dump_valid high. It also keeps
// dump_data and dump_index stable, except in the overwrite build.
//
// Signals:
//   dump_data  [DATA_WIDTH] producer -> consumer, captured sum
//   dump_valid [1]          producer -> consumer, slot holds a dump
//   dump_ready [1]          consumer -> producer, consumer accepts
//   dump_index [CNT_WIDTH]  producer -> consumer, dump sequence number
interface acc_dump_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [CNT_WIDTH-1:0]  dump_index;

  modport master (
    output dump_data,
    output dump_valid,
    output dump_index,
    input  dump_ready
  );

  modport slave (
    input  dump_data,
    input  dump_valid,
    input  dump_index,
    output dump_ready
  );
endinterface

// File: rtl/acc_dump.sv
// acc_dump: integrate-and-dump controller that sits after an accumulator.
// It counts enabled samples. Every ACC_LEN samples it captures the
// accumulator sum into a one-entry output slot and pulses acc_clr so
// that the accumulator restarts from zero. A dump that cannot be placed
// because the slot is still full is lost. Each loss increments a
// saturating drop counter.
//
// Build option: define ACC_DUMP_OVERWRITE_EN and a conflicting new dump
// replaces the held dump. The replaced dump is the one counted as lost.
// Without the macro, the new dump is discarded and counted as lost.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          sample valid (same enable that drives the accumulator)
//   data_in     accumulator running sum
//   acc_clr     one-cycle clear to the accumulator (combinational)
//   drop_count  saturating count of lost dumps
//   cnt_dbg     sample counter state, for observation
//   dump        acc_dump_if.master output port (data/valid/ready/index)
module acc_dump #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_LEN    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  acc_clr,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  cnt_dbg,
  acc_dump_if.master            dump
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACC_LEN - 1);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  index_q, index_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic                  term;
  logic                  accept;
  logic                  conflict;

  always_comb begin
    // Reset gates term, so that no clear pulse is issued while in reset.
    term     = ~rst & en & (cnt_q == CNT_LAST);
    accept   = valid_q & dump.dump_ready;
    // The slot stays full past this edge, so a new dump has nowhere to go.
    conflict = term & valid_q & ~dump.dump_ready;

    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    drop_d  = drop_q;

    if (en) begin
      cnt_d = term ? '0 : cnt_q + CNT_WIDTH'(1);
    end

    if (conflict) begin
      if (drop_q != '1) begin
        drop_d = drop_q + CNT_WIDTH'(1);
      end
`ifdef ACC_DUMP_OVERWRITE_EN
      data_d  = data_in;
      index_d = index_q + CNT_WIDTH'(1);
`else
      data_d  = data_q;
      index_d = index_q;
`endif
    end else if (term) begin
      // Either the slot is empty, or it drains on this same edge.
      valid_d = 1'b1;
      data_d  = data_in;
      index_d = index_q + CNT_WIDTH'(1);
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      drop_q  <= drop_d;
    end
  end

  assign acc_clr         = term;
  assign drop_count      = drop_q;
  assign cnt_dbg         = cnt_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_index = index_q;

endmodule

// File: tb/tb_acc_dump.sv
// tb_acc_dump: directed bench for acc_dump with ACC_LEN=4. A small
// accumulator model sits upstream. Its output is the registered sum plus
// the current sample. It clears on rst or acc_clr, so a full window of
// 4 samples of value inc sums to 4*inc.
module tb_acc_dump;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int AL = 4;
`ifdef ACC_DUMP_OVERWRITE_EN
  localparam int OVR = 1;
`else
  localparam int OVR = 0;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic [DW-1:0] data_in;
  logic          acc_clr;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] cnt_dbg;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] inc;

  int total = 0;
  int bad   = 0;

  acc_dump_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dump_if ();

  acc_dump #(.DATA_WIDTH(DW), .ACC_LEN(AL), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_in    (data_in),
    .acc_clr    (acc_clr),
    .drop_count (drop_count),
    .cnt_dbg    (cnt_dbg),
    .dump       (dump_if.master)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // upstream accumulator model
  assign data_in = acc_q + (en ? inc : DW'(0));
  always @(posedge clk) begin
    if (rst || acc_clr) acc_q <= '0;
    else                acc_q <= data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // drive inputs shortly after an edge; pre-edge combinational checks follow
  task automatic drive(input bit e, input bit r, input bit rs);
    en                 = e;
    dump_if.dump_ready = r;
    rst                = rs;
    #2;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(dump_if.dump_valid), 0);
    check({tag, "_data"},  32'(dump_if.dump_data),  0);
    check({tag, "_index"}, 32'(dump_if.dump_index), 0);
    check({tag, "_drop"},  32'(drop_count),         0);
    check({tag, "_cnt"},   32'(cnt_dbg),            0);
  endtask

  initial begin
    int t;
    int ei;
    acc_q = '0;
    inc   = DW'(3);
    rst   = 1'b1;
    en    = 1'b0;
    dump_if.dump_ready = 1'b0;
    tick();
    drive(1, 1, 1);
    check("rst_clr", 32'(acc_clr), 0);
    tick();
    check_zero("rst");

    // continuous enable, ready high: dump of 12 after every 4th sample
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 0);
      check($sformatf("t1_clr_%0d", i), 32'(acc_clr), (i % 4 == 3) ? 1 : 0);
      tick();
      check($sformatf("t1_valid_%0d", i), 32'(dump_if.dump_valid), (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 3) begin
        check($sformatf("t1_data_%0d", i),  32'(dump_if.dump_data),  12);
        check($sformatf("t1_index_%0d", i), 32'(dump_if.dump_index), i / 4 + 1);
      end
    end
    check("t1_drop", 32'(drop_count), 0);
    drive(0, 1, 0);
    tick();
    check("t1_drain", 32'(dump_if.dump_valid), 0);

    // enable gaps: en 1,0,1,0..., dump every 8 cycles, counter holds on en=0
    for (int i = 0; i < 16; i++) begin
      drive((i % 2) == 0, 1, 0);
      tick();
      check($sformatf("t2_cnt_%0d", i), 32'(cnt_dbg), (i / 2 + 1) % 4);
      check($sformatf("t2_valid_%0d", i), 32'(dump_if.dump_valid), (i == 6 || i == 14) ? 1 : 0);
      if (i == 6 || i == 14) begin
        check($sformatf("t2_data_%0d", i),  32'(dump_if.dump_data),  12);
        check($sformatf("t2_index_%0d", i), 32'(dump_if.dump_index), (i == 6) ? 4 : 5);
      end
    end

    // back-pressure over 11 windows after a fresh reset
    drive(0, 0, 1);
    tick();
    check_zero("t3_rst");
    for (int i = 0; i < 44; i++) begin
      drive(1, 0, 0);
      tick();
      t = (i + 1) / 4;
      check($sformatf("t3_valid_%0d", i), 32'(dump_if.dump_valid), (t >= 1) ? 1 : 0);
      if (t >= 1) begin
        check($sformatf("t3_data_%0d", i),  32'(dump_if.dump_data),  12);
        check($sformatf("t3_index_%0d", i), 32'(dump_if.dump_index), OVR ? t : 1);
        check($sformatf("t3_drop_%0d", i),  32'(drop_count),         t - 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0);
      tick();
      check($sformatf("t3r_valid_%0d", i), 32'(dump_if.dump_valid), (i == 3) ? 1 : 0);
    end
    check("t3r_index", 32'(dump_if.dump_index), OVR ? 12 : 2);
    check("t3r_data",  32'(dump_if.dump_data),  12);
    check("t3r_drop",  32'(drop_count),         10);

    // ready raised on exactly the term edge while the slot is full
    inc = DW'(5);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      tick();
      check($sformatf("t4_hold_%0d", i), 32'(dump_if.dump_index), OVR ? 12 : 2);
    end
    drive(1, 1, 0);
    check("t4_clr", 32'(acc_clr), 1);
    tick();
    check("t4_valid", 32'(dump_if.dump_valid), 1);
    check("t4_data",  32'(dump_if.dump_data),  20);
    check("t4_index", 32'(dump_if.dump_index), OVR ? 13 : 3);
    check("t4_drop",  32'(drop_count),         10);
    drive(0, 1, 0);
    tick();
    check("t4_drain", 32'(dump_if.dump_valid), 0);

    // reset after 2 of 4 samples
    inc = DW'(3);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0);
      tick();
    end
    check("t5_cnt_pre", 32'(cnt_dbg), 2);
    drive(1, 1, 1);
    tick();
    check_zero("t5_rst");
    ei = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0);
      tick();
      ei++;
      check($sformatf("t5_valid_%0d", i), 32'(dump_if.dump_valid), (ei == 4) ? 1 : 0);
    end
    check("t5_data",  32'(dump_if.dump_data),  12);
    check("t5_index", 32'(dump_if.dump_index), 1);

    // reset on the would-be terminal cycle: no clear pulse, no dump
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0);
      tick();
    end
    check("t6_cnt_pre", 32'(cnt_dbg), 3);
    drive(1, 1, 1);
    check("t6_clr", 32'(acc_clr), 0);
    tick();
    check("t6_valid", 32'(dump_if.dump_valid), 0);
    check("t6_cnt",   32'(cnt_dbg),            0);
    check("t6_index", 32'(dump_if.dump_index), 0);
    drive(0, 1, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
